// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/ack and the decode-side
// valid/ready handshake, including the control-unit redirect.
interface fetch_unit_if;
    logic        imem_req;
    logic [25:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [25:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        load_pc;
    logic [25:0] load_pc_val;

    modport master (
        output imem_req, imem_addr,
        output instruction, instr_pc, instr_valid,
        input  imem_ack, imem_rdata,
        input  instr_ready, load_pc, load_pc_val
    );

    modport slave (
        input  imem_req, imem_addr,
        input  instruction, instr_pc, instr_valid,
        output imem_ack, imem_rdata,
        output instr_ready, load_pc, load_pc_val
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word fetch with a one-entry prefetch
// buffer, decode backpressure and redirect with squash of in-flight reads.
module fetch_unit #(
    parameter logic [25:0] RESET_PC = 26'd0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]  state;
    logic [25:0] req_addr;
    logic [25:0] target;
    logic [31:0] out_instr;
    logic [25:0] out_pc;
    logic        out_valid;
    logic [31:0] buf_instr;
    logic [25:0] buf_pc;
    logic        buf_valid;

    logic accept;
    logic redirect;
    logic ack;
    logic fetch_ack;
    logic to_out;
    logic out_next;
    logic buf_next;

    assign bus.imem_req    = !rst && (state != STALL);
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = out_valid;
    assign bus.instruction = out_valid ? out_instr : 32'h0;
    assign bus.instr_pc    = out_valid ? out_pc : 26'h0;

    // An ack only counts while a request is actually being driven.
    assign accept    = out_valid & bus.instr_ready;
    assign redirect  = accept & bus.load_pc;
    assign ack       = bus.imem_ack & bus.imem_req;
    assign fetch_ack = ack & (state == FETCH);
    assign to_out    = fetch_ack
                     & (!out_valid | (accept & !buf_valid));

    always_comb begin
        out_next = to_out
                 | (out_valid & !accept)
                 | (accept & buf_valid);
        buf_next = (fetch_ack & !to_out)
                 | (buf_valid & !accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            req_addr  <= RESET_PC;
            target    <= 26'd0;
            out_instr <= 32'h0;
            out_pc    <= 26'd0;
            out_valid <= 1'b0;
            buf_instr <= 32'h0;
            buf_pc    <= 26'd0;
            buf_valid <= 1'b0;
        end else if (redirect) begin
            out_valid <= 1'b0;
            buf_valid <= 1'b0;
            // Without an ack the old read is still in flight: squash it.
            if (ack || state == STALL) begin
                req_addr <= bus.load_pc_val;
                state    <= FETCH;
            end else begin
                target <= bus.load_pc_val;
                state  <= DRAIN;
            end
        end else begin
            if (to_out) begin
                out_instr <= bus.imem_rdata;
                out_pc    <= req_addr;
            end else if (accept && buf_valid) begin
                out_instr <= buf_instr;
                out_pc    <= buf_pc;
            end
            if (fetch_ack && !to_out) begin
                buf_instr <= bus.imem_rdata;
                buf_pc    <= req_addr;
            end
            out_valid <= out_next;
            buf_valid <= buf_next;
            unique case (state)
                FETCH: begin
                    if (fetch_ack)
                        req_addr <= req_addr + 26'd1;
                    if (out_next && buf_next)
                        state <= STALL;
                end
                DRAIN: begin
                    if (ack) begin
                        req_addr <= target;
                        state    <= FETCH;
                    end
                end
                STALL: begin
                    if (accept)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 26'd0, the word address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  26  word address of the request.
REQ-006 imem_ack  input  1  memory completes the request this cycle; imem_rdata is valid.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instruction  output  32  instruction presented to decode.
REQ-009 instr_pc  output  26  word address of the presented instruction.
REQ-010 instr_valid  output  1  instruction/instr_pc are valid.
REQ-011 instr_ready  input  1  decode/execute accepts the presented instruction this cycle.
REQ-012 load_pc  input  1  redirect request from the control unit.
REQ-013 load_pc_val  input  26  redirect target word address.

Function
REQ-014 Accept = instr_valid & instr_ready; load_pc/load_pc_val shall be sampled only in accept cycles and ignored otherwise.
REQ-015 Storage: output register (instruction, instr_pc, instr_valid) plus a one-entry prefetch buffer (data, pc, valid); req_addr and target registers, 26 bits each.
REQ-016 States: FETCH (useful request outstanding), DRAIN (squashed request outstanding), STALL (no request; both entries full).
REQ-017 imem_req shall be 1 in FETCH and DRAIN, and 0 in STALL and whenever rst=1.
REQ-018 imem_addr shall equal req_addr and shall remain stable from the cycle imem_req rises until the imem_ack cycle, inclusive.
REQ-019 After an imem_ack in FETCH, req_addr shall increment by 1 modulo 2^26, so 26'h3FFFFFF wraps to 0; back-to-back requests are permitted with imem_req held high.
REQ-020 Ack data routing in FETCH: the data goes to the output register if that register is empty or being accepted this cycle with the buffer empty; otherwise it goes to the prefetch buffer, tagged with its address.
REQ-021 On an accept with no ack routed to the output register: if the buffer is valid, the buffer moves to the output register and the buffer clears; otherwise instr_valid shall go to 0.
REQ-022 Transitions: FETCH->STALL when, after the cycle's update, both entries are full. STALL->FETCH on any accept, with the next request issued in the following cycle.
REQ-023 Latency: an imem_ack in cycle N into an empty output register shall give instr_valid=1 in cycle N+1; there is no combinational path from imem_rdata to instruction.
REQ-024 instruction shall read 32'h0 (NOP) and instr_pc shall read 0 whenever instr_valid=0.
REQ-025 Redirect (accept & load_pc): the output register and the prefetch buffer shall both be invalidated the next cycle, and any ack data in the same cycle is discarded.
REQ-026 Redirect with ack in the same cycle, or redirect from STALL: req_addr shall become load_pc_val and the state FETCH.
REQ-027 Redirect in FETCH with the request outstanding and no ack: target shall become load_pc_val and the state DRAIN; req_addr is held.
REQ-028 In DRAIN, ack data shall be discarded; on ack, req_addr shall become target and the state FETCH.
REQ-029 Redirect to the address of the instruction already held shall still flush and refetch that address.
REQ-030 Accept with load_pc=0 shall be a normal sequential advance.

Reset
REQ-031 While rst=1 at a clock edge: state shall become FETCH, req_addr RESET_PC, target 0, and instr_valid, buffer valid and instr_pc 0, with instruction 32'h0.
REQ-032 Reset asserted mid-request (including DRAIN) shall abandon the request; the memory shall tolerate a dropped imem_req, and a late ack shall be ignored because imem_req=0.
REQ-033 The first imem_req=1 (imem_addr=RESET_PC) shall occur in the first cycle after rst deasserts.

Verification
REQ-034 Streaming: memory acks in the same cycle as each request, instr_ready=1 -> instr_pc sequence 0,1,2,3, one instruction per cycle after the first, with instruction matching memory.
REQ-035 Backpressure: instr_ready=0 for 5 cycles -> after 2 acks imem_req=0 (STALL); on release, instr_pc 0 then 1 with no loss or duplication, then a new request at 2.
REQ-036 Redirect with outstanding request: accept at pc 4 with load_pc=1, load_pc_val=26'h100, and the ack for 5 arriving 3 cycles later -> imem_addr=5 stays stable, the 5 data is dropped, the next request is 26'h100, and the next instr_pc is 26'h100.
REQ-037 Redirect with a full prefetch buffer -> the buffered instruction is never presented and the next instr_pc equals the target.
REQ-038 Wrap: load_pc_val=26'h3FFFFFF -> instr_pc 26'h3FFFFFF then 0.
REQ-039 Reset mid-DRAIN: rst pulsed for 1 cycle -> imem_req=0 during reset, next request at RESET_PC, and instr_valid=0 until that ack.
